mem_line_arbiter: RTL and testbench

- Two-requester, round-robin arbiter and burst sequencer in front of the single-port word memory: 32-bit words, 1-cycle registered read latency, write on the clock edge when the write request is high.
- Each requester (e.g. I-cache refill = 0, D-cache refill/writeback = 1) transfers whole cache lines.
- The block serialises each line into word accesses and assembles read data back into a line.

---
 rtl/mem_line_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_line_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_line_arbiter.sv
// Two-requester round-robin arbiter that serialises cache-line reads/writes
// into single-word accesses on a 1-cycle-latency word memory.
module mem_line_arbiter #(
   parameter int unsigned ADDR_LEN      = 11,
   parameter int unsigned LINE_ADDR_LEN = 3
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  req0,
   input  logic                                  req1,
   input  logic                                  we0,
   input  logic                                  we1,
   input  logic [ADDR_LEN-LINE_ADDR_LEN-1:0]     line_addr0,
   input  logic [ADDR_LEN-LINE_ADDR_LEN-1:0]     line_addr1,
   input  logic [32*(1<<LINE_ADDR_LEN)-1:0]      wr_line0,
   input  logic [32*(1<<LINE_ADDR_LEN)-1:0]      wr_line1,
   output logic                                  done0,
   output logic                                  done1,
   output logic [32*(1<<LINE_ADDR_LEN)-1:0]      rd_line,
   output logic                                  busy,
   output logic [ADDR_LEN-1:0]                   mem_addr,
   output logic                                  mem_wr_req,
   output logic [31:0]                           mem_wr_data,
   input  logic [31:0]                           mem_rd_data
);

   localparam int unsigned LW = LINE_ADDR_LEN;
   localparam int unsigned LA = ADDR_LEN - LINE_ADDR_LEN;
   localparam int unsigned N  = 1 << LINE_ADDR_LEN;
   localparam int unsigned CW = LINE_ADDR_LEN + 1;

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic            last_grant;
   logic            gid;
   logic [LA-1:0]   line_q;
   logic [31:0]     wr_word [N];

   logic            gnt1;
   logic            sel_we;
   logic [LA-1:0]   sel_line;
   logic [32*N-1:0] sel_wr;
   logic [LW-1:0]   nxt;
   logic [LW-1:0]   cap;

   // Requester selection: on a tie the one not granted last time wins.
   always_comb begin
      gnt1     = req1 & (~req0 | ~last_grant);
      sel_we   = gnt1 ? we1 : we0;
      sel_line = gnt1 ? line_addr1 : line_addr0;
      sel_wr   = gnt1 ? wr_line1 : wr_line0;
      nxt      = cnt[LW-1:0] + LW'(1);
      cap      = cnt[LW-1:0] - LW'(1);
   end

   // Memory-side outputs are loaded one edge ahead so they line up with cnt.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         last_grant  <= 1'b1;
         gid         <= 1'b0;
         line_q      <= '0;
         done0       <= 1'b0;
         done1       <= 1'b0;
         busy        <= 1'b0;
         mem_addr    <= '0;
         mem_wr_req  <= 1'b0;
         mem_wr_data <= '0;
         rd_line     <= '0;
         for (int k = 0; k < N; k++) wr_word[k] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  gid        <= gnt1;
                  last_grant <= gnt1;
                  line_q     <= sel_line;
                  cnt        <= '0;
                  busy       <= 1'b1;
                  mem_addr   <= {sel_line, {LW{1'b0}}};
                  for (int k = 0; k < N; k++) wr_word[k] <= sel_wr[32*k +: 32];
                  if (sel_we) begin
                     state       <= WRITE;
                     mem_wr_req  <= 1'b1;
                     mem_wr_data <= sel_wr[31:0];
                  end else begin
                     state <= READ;
                  end
               end
            end
            READ: begin
               if (cnt != '0) begin
                  for (int k = 0; k < N; k++)
                     if (cap == LW'(k)) rd_line[32*k +: 32] <= mem_rd_data;
               end
               if (cnt == CW'(N)) begin
                  state    <= DONE;
                  done0    <= ~gid;
                  done1    <= gid;
                  mem_addr <= '0;
               end else begin
                  cnt      <= cnt + CW'(1);
                  mem_addr <= (cnt == CW'(N - 1)) ? '0 : {line_q, nxt};
               end
            end
            WRITE: begin
               if (cnt == CW'(N - 1)) begin
                  state       <= DONE;
                  done0       <= ~gid;
                  done1       <= gid;
                  mem_wr_req  <= 1'b0;
                  mem_addr    <= '0;
                  mem_wr_data <= '0;
               end else begin
                  cnt         <= cnt + CW'(1);
                  mem_addr    <= {line_q, nxt};
                  mem_wr_data <= wr_word[nxt];
               end
            end
            DONE: begin
               state <= IDLE;
               done0 <= 1'b0;
               done1 <= 1'b0;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Directed bench for mem_line_arbiter with a behavioural 1-cycle word memory.
module tb_mem_line_arbiter;

   localparam int unsigned ADDR_LEN = 11;
   localparam int unsigned LW       = 3;
   localparam int unsigned N        = 8;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [ADDR_LEN-LW-1:0] line_addr0 = '0, line_addr1 = '0;
   logic [32*N-1:0]        wr_line0 = '0, wr_line1 = '0;
   logic                   done0, done1, busy, mem_wr_req;
   logic [32*N-1:0]        rd_line;
   logic [ADDR_LEN-1:0]    mem_addr;
   logic [31:0]            mem_wr_data;
   logic [31:0]            mem_rd_data;

   logic [31:0] mem [0:(1<<ADDR_LEN)-1];
   logic        mem_ready = 1'b0;

   int errors = 0;
   int checks = 0;

   mem_line_arbiter #(.ADDR_LEN(ADDR_LEN), .LINE_ADDR_LEN(LW)) dut (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .line_addr0(line_addr0), .line_addr1(line_addr1),
      .wr_line0(wr_line0), .wr_line1(wr_line1),
      .done0(done0), .done1(done1), .rd_line(rd_line), .busy(busy),
      .mem_addr(mem_addr), .mem_wr_req(mem_wr_req),
      .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int i);
      logic [31:0] tbl [16];
      tbl = '{32'h0, 32'h1, 32'h7, 32'hc, 32'hd, 32'hf, 32'h2, 32'h3,
              32'ha, 32'h4, 32'h9, 32'h8, 32'h6, 32'he, 32'h5, 32'hb};
      return (i < 16) ? tbl[i] : 32'h0;
   endfunction

   function automatic logic [32*N-1:0] mk_line(input logic [31:0] base);
      logic [32*N-1:0] l;
      for (int k = 0; k < N; k++) l[32*k +: 32] = base + 32'(k);
      return l;
   endfunction

   function automatic logic [32*N-1:0] orig_line1();
      logic [32*N-1:0] l;
      for (int k = 0; k < N; k++) l[32*k +: 32] = init_word(8 + k);
      return l;
   endfunction

   function automatic logic [32*N-1:0] mem_line(input int line);
      logic [32*N-1:0] l;
      for (int k = 0; k < N; k++) l[32*k +: 32] = mem[line*N + k];
      return l;
   endfunction

   // Single-port memory: preloaded on the first edge, then write-on-edge, registered read.
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < (1 << ADDR_LEN); i++) mem[i] <= init_word(i);
         mem_ready <= 1'b1;
      end else if (mem_wr_req) begin
         mem[mem_addr] <= mem_wr_data;
      end
      mem_rd_data <= mem[mem_addr];
   end

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (done0 !== 1'b0 || done1 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b%b want 00", done0, done1); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (mem_wr_req !== 1'b0 || mem_addr !== '0 || mem_wr_data !== '0) begin errors++; $display("FAIL reset_mem: req=%b addr=%h data=%h want 0", mem_wr_req, mem_addr, mem_wr_data); end
      checks++; if (rd_line !== '0) begin errors++; $display("FAIL reset_rd_line: got %h want 0", rd_line); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
   endtask

   task automatic wait_done0(input int max_cyc, output int cyc);
      cyc = 0;
      while (done0 !== 1'b1 && cyc < max_cyc) begin @(negedge clk); cyc++; end
      if (done0 !== 1'b1) begin
         checks++; errors++;
         $display("FAIL timeout_done0: no done0 within %0d cycles", max_cyc);
      end
   endtask

   task automatic test_read_line();
      req0 = 1'b1; we0 = 1'b0; line_addr0 = 8'd1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         checks++; if (mem_addr !== 11'(7 + i) || mem_wr_req !== 1'b0 || done0 !== 1'b0) begin
            errors++; $display("FAIL read_addr cyc %0d: addr=%0d wr=%b done0=%b want addr=%0d wr=0 done0=0", i, mem_addr, mem_wr_req, done0, 7 + i);
         end
      end
      @(negedge clk);
      checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL read_done_early: done0=%b at t+9 want 0", done0); end
      @(negedge clk);
      checks++; if (done0 !== 1'b1 || done1 !== 1'b0) begin errors++; $display("FAIL read_done: done0=%b done1=%b at t+10 want 1 0", done0, done1); end
      checks++; if (rd_line !== orig_line1()) begin errors++; $display("FAIL read_data: got %h want %h", rd_line, orig_line1()); end
      req0 = 1'b0;
      @(negedge clk);
      checks++; if (done0 !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL read_after: done0=%b busy=%b want 0 0", done0, busy); end
   endtask

   task automatic test_write_line();
      int c;
      req1 = 1'b1; we1 = 1'b1; line_addr1 = 8'd0; wr_line1 = mk_line(32'd100);
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         checks++; if (mem_wr_req !== 1'b1 || mem_addr !== 11'(i - 1) || mem_wr_data !== 32'(99 + i) || done1 !== 1'b0) begin
            errors++; $display("FAIL write_beat %0d: wr=%b addr=%0d data=%0d done1=%b want 1 %0d %0d 0", i, mem_wr_req, mem_addr, mem_wr_data, done1, i - 1, 99 + i);
         end
      end
      @(negedge clk);
      checks++; if (done1 !== 1'b1 || done0 !== 1'b0 || mem_wr_req !== 1'b0) begin
         errors++; $display("FAIL write_done: done1=%b done0=%b wr=%b at t+9 want 1 0 0", done1, done0, mem_wr_req);
      end
      req1 = 1'b0; we1 = 1'b0;
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b0; line_addr0 = 8'd0;
      wait_done0(20, c);
      checks++; if (rd_line !== mk_line(32'd100)) begin errors++; $display("FAIL write_readback: got %h want %h", rd_line, mk_line(32'd100)); end
      req0 = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_contention();
      int n0, n1, d0, d1, ovl;
      logic [32*N-1:0] r0, r1;
      n0 = 0; n1 = 0; d0 = 0; d1 = 0; ovl = 0; r0 = '0; r1 = '0;
      rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
      req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; line_addr0 = 8'd1; line_addr1 = 8'd0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (done0 === 1'b1 && done1 === 1'b1) ovl++;
         if (done0 === 1'b1) begin n0++; d0 = i; r0 = rd_line; req0 = 1'b0; end
         if (done1 === 1'b1) begin n1++; d1 = i; r1 = rd_line; req1 = 1'b0; end
      end
      req0 = 1'b0; req1 = 1'b0;
      checks++; if (ovl !== 0) begin errors++; $display("FAIL contention_overlap: %0d overlapping cycles want 0", ovl); end
      checks++; if (n0 !== 1 || n1 !== 1) begin errors++; $display("FAIL contention_count: done0=%0d done1=%0d want 1 1", n0, n1); end
      checks++; if (d0 !== 10 || d1 !== 21) begin errors++; $display("FAIL contention_order: done0@%0d done1@%0d want 10 21", d0, d1); end
      checks++; if (r0 !== orig_line1()) begin errors++; $display("FAIL contention_data0: got %h want %h", r0, orig_line1()); end
      checks++; if (r1 !== mk_line(32'd100)) begin errors++; $display("FAIL contention_data1: got %h want %h", r1, mk_line(32'd100)); end
   endtask

   task automatic test_back_to_back();
      int order [4];
      int at [4];
      int n, idle;
      n = 0; idle = 0;
      for (int k = 0; k < 4; k++) begin order[k] = -1; at[k] = 0; end
      req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; line_addr0 = 8'd1; line_addr1 = 8'd0;
      for (int i = 1; i <= 80 && n < 4; i++) begin
         @(negedge clk);
         if (n >= 1 && busy === 1'b0) idle++;
         if (done0 === 1'b1 || done1 === 1'b1) begin
            order[n] = (done1 === 1'b1) ? 1 : 0;
            at[n] = i;
            n++;
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checks++; if (order[k] !== (k % 2)) begin errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, order[k], k % 2); end
      end
      checks++; if (at[3] - at[0] !== 33) begin errors++; $display("FAIL rr_spacing: span %0d want 33", at[3] - at[0]); end
      checks++; if (idle !== 3) begin errors++; $display("FAIL rr_idle: %0d idle cycles want 3", idle); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_write();
      logic [32*N-1:0] exp_l;
      exp_l = orig_line1();
      exp_l[31:0] = 32'd200; exp_l[63:32] = 32'd201; exp_l[95:64] = 32'd202;
      req0 = 1'b1; we0 = 1'b1; line_addr0 = 8'd1; wr_line0 = mk_line(32'd200);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks++; if (done0 !== 1'b0 || busy !== 1'b0 || mem_wr_req !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl: done0=%b busy=%b wr=%b want 0", done0, busy, mem_wr_req); end
      checks++; if (mem_addr !== '0 || mem_wr_data !== '0 || rd_line !== '0) begin errors++; $display("FAIL rst_mid_data: addr=%h data=%h rd_line=%h want 0", mem_addr, mem_wr_data, rd_line); end
      req0 = 1'b0; we0 = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (done0 !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_after: done0=%b busy=%b want 0 0", done0, busy); end
      checks++; if (mem_line(1) !== exp_l) begin errors++; $display("FAIL rst_mid_mem: got %h want %h", mem_line(1), exp_l); end
   endtask

   task automatic test_write_latch();
      int c;
      req0 = 1'b1; we0 = 1'b1; line_addr0 = 8'd1; wr_line0 = mk_line(32'd300);
      @(negedge clk);
      wr_line0 = mk_line(32'hdead0000); line_addr0 = 8'd0; we0 = 1'b0;
      wait_done0(20, c);
      checks++; if (c !== 8) begin errors++; $display("FAIL latch_latency: done0 %0d cycles after grant+1 want 8", c); end
      req0 = 1'b0;
      @(negedge clk);
      checks++; if (mem_line(1) !== mk_line(32'd300)) begin errors++; $display("FAIL latch_data: got %h want %h", mem_line(1), mk_line(32'd300)); end
      checks++; if (mem_line(0) !== mk_line(32'd100)) begin errors++; $display("FAIL latch_other_line: got %h want %h", mem_line(0), mk_line(32'd100)); end
   endtask

   initial begin
      test_reset();
      test_read_line();
      test_write_line();
      test_contention();
      test_back_to_back();
      test_reset_mid_write();
      test_write_latch();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
